calc_op_sequencer: RTL and testbench
====================================

# calc_op_sequencer

Sequential operation controller for the 4-bit switch calculator. It captures two operands and an opcode on a start pulse, then runs the selected operation. Add and subtract take one execute cycle, multiply runs as a 4-cycle shift-add, and divide is handed to the external multi-cycle divider over a start/done handshake. The registered 8-bit result, sign and error flags feed the LED bank and the binary-to-BCD/seven-segment path, replacing the free-running combinational selection.

## Interface
- DIV_TIMEOUT, 32: maximum cycles spent in DIV_WAIT before the operation is aborted with err.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- go  in  1  start request, sampled only in IDLE; level or pulse, one operation per accepted cycle.
- op  in  2  operation select: 00 add, 01 sub, 10 div, 11 mul.
- a  in  4  operand A (switches [7:4]).
- b  in  4  operand B (switches [3:0]).
- div_start  out  1  one-cycle request to the divider.
- div_q  out  4  dividend to the divider; latched A.
- div_m  out  4  divisor to the divider; latched B.
- div_done  in  1  divider completion strobe.
- div_quot  in  4  divider quotient; valid with div_done.
- div_rem  in  4  divider remainder; valid with div_done.
- result  out  8  registered result.
- neg  out  1  result is a negative two's-complement difference.
- err  out  1  divide-by-zero or divider timeout.
- valid  out  1  one-cycle pulse when result, neg and err are updated.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: go=1 latches a, b and op, clears err and goes to EXEC.
  - EXEC, add/sub: computes, then goes to DONE.
  - EXEC, mul: loads the multiplier, then goes to MUL.
  - EXEC, div with B≠0: goes to DIV_REQ.
  - EXEC, div with B=0: sets err, then goes to DONE.
  - MUL: 4 iterations, then goes to DONE.
  - DIV_REQ: asserts div_start for one cycle, then goes to DIV_WAIT.
  - DIV_WAIT: on div_done, captures the result and goes to DONE. On timeout, sets err and goes to DONE.
  - DONE: valid=1 for one cycle, then returns to IDLE.
- Add: result = {3'b0, A+B}, 5-bit sum zero-extended; neg=0.
- Sub: result = A−B as 8-bit two's complement, sign-extended from 5 bits; neg=1 when A<B.
- Mul: unsigned shift-add. Each cycle adds A<<i to the accumulator when B[i]=1, for i = 0..3. The final value is the full 8-bit product; neg=0.
- Div: result = {div_rem, div_quot}. On err, result = 8'h00.
- Timeout: a 6-bit cycle counter starts at 0 on entry to DIV_WAIT. When it reaches DIV_TIMEOUT−1 without div_done, the block takes the error exit.
- div_done outside DIV_WAIT is ignored.
- go outside IDLE is ignored; there is no queuing.
- Changes on a, b or op after acceptance have no effect. div_q and div_m are driven from the latched copies.
- result, neg and err hold their value from DONE until the next accepted go. At acceptance, err clears and result/neg hold.

## Timing
- Reset values: state IDLE; result 8'h00; neg, err, valid, busy and div_start all 0; counters 0.
- Reset mid-operation returns the block to IDLE immediately, with no valid pulse. A later div_done from the interrupted divide is ignored.
- Latency, counted from the edge that samples go=1 to the first edge where valid=1:
  - add/sub: 2
  - mul: 6 (EXEC, 4 MUL, DONE)
  - div by zero: 2
  - div: 3 + k, where k is the number of DIV_WAIT cycles up to and including the div_done cycle
  - timeout: 3 + DIV_TIMEOUT
- busy rises on the cycle after go is accepted and falls on the cycle after valid.
- Back-to-back: go held high restarts the block on the cycle after DONE (one IDLE cycle minimum).
- div_done in the same cycle as the timeout limit: div_done wins and err=0.

## Structure
- Shared package calc_pkg holds:
  - the op_t enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11);
  - the state enum;
  - the width constants OPW=4 and RESW=8.
- One sub-module, calc_shift_mul: the 4-cycle shift-add multiplier with load/step/done. The FSM, counters and result muxing stay in calc_op_sequencer.

## Test plan
- Add: a=9, b=7, op=00, go pulse → valid at latency 2; result=8'h10, neg=0, err=0, busy high for 2 cycles.
- Sub: a=3, b=5, op=01 → result=8'hFE, neg=1.
- Sub: a=5, b=3 → result=8'h02, neg=0.
- Mul: a=15, b=15, op=11 → valid at latency 6, result=8'hE1.
- Mul: a=0, b=9 → result=8'h00.
- Div: a=13, b=4, op=10 → div_start for one cycle with div_q=13, div_m=4. Model returns div_done after 5 cycles with quot=3, rem=1 → result=8'h13, err=0, valid at latency 8.
- Div: b=0 → no div_start, err=1, result=8'h00, valid at latency 2.
- Div with the model never asserting div_done → err=1 at latency 3+DIV_TIMEOUT.
- go pulses during busy are ignored.
- clr low during the MUL state → all outputs return to reset values. A following add 1+1 gives 8'h02.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the switch-calculator operation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  localparam int OPW  = 4;  // operand width (one switch nibble)
  localparam int RESW = 8;  // result width (LED bank / BCD path)

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Start/done handshake between the sequencer and the external divider.
// Latency: div_start is a one-cycle request; div_done strobes the answer.
// Backpressure: none; the sequencer waits on div_done with a timeout.
interface calc_op_sequencer_if;
  import calc_pkg::*;

  logic            div_start;
  logic [OPW-1:0]  div_q;
  logic [OPW-1:0]  div_m;
  logic            div_done;
  logic [OPW-1:0]  div_quot;
  logic [OPW-1:0]  div_rem;

  // Sequencer side: issues the request and operands.
  modport master (
    output div_start, div_q, div_m,
    input  div_done, div_quot, div_rem
  );

  // Divider side: receives the request and returns the answer.
  modport slave (
    input  div_start, div_q, div_m,
    output div_done, div_quot, div_rem
  );

endinterface

// File: rtl/calc_shift_mul.sv
// Unsigned 4x4 shift-add multiplier, one partial product per step.
// Latency: load, then OPW steps; done flags the step that completes the product.
// Backpressure: none; the caller asserts step every cycle until done.
module calc_shift_mul
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [RESW-1:0] prod,   // accumulator value after the current step
  output logic            done    // current step is the last one
);

  localparam int IDXW = $clog2(OPW);

  logic [RESW-1:0] mcand;
  logic [OPW-1:0]  mplier;
  logic [RESW-1:0] acc;
  logic [IDXW-1:0] idx;

  // Add the shifted multiplicand when the current multiplier bit is set.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = (idx == IDXW'(OPW - 1));

  // Load the operands, then shift multiplicand left / multiplier right per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      idx    <= '0;
    end else if (load) begin
      mcand  <= {{(RESW-OPW){1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      idx    <= '0;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= prod;
      idx    <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Captures operands/opcode on go and sequences add, sub, shift-add mul or external divide.
// Latency: add/sub 2, mul 6, div 3+k (k DIV_WAIT cycles), div-by-zero 2, timeout 3+DIV_TIMEOUT.
// Backpressure: go is only sampled in IDLE; requests while busy are dropped, never queued.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DIV_TIMEOUT = 32
)
(
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic [1:0]       op,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [RESW-1:0]  result,
  output logic             neg,
  output logic             err,
  output logic             valid,
  output logic             busy,
  calc_op_sequencer_if.master div_bus
);

  localparam logic [5:0] TMO_LAST = 6'(DIV_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [OPW-1:0]  a_r, b_r;
  op_t             op_r;
  logic [5:0]      wait_cnt;

  logic            accept, ld_res, mul_load, mul_step, div_start_c;
  logic [RESW-1:0] res_nxt;
  logic            neg_nxt, err_nxt;
  logic [RESW-1:0] mul_prod;
  logic            mul_done;
  logic [OPW:0]    sum5, diff5;
  logic            wait_last;

  assign sum5      = {1'b0, a_r} + {1'b0, b_r};
  assign diff5     = {1'b0, a_r} - {1'b0, b_r};
  assign wait_last = (wait_cnt == TMO_LAST);

  assign div_bus.div_start = div_start_c;
  assign div_bus.div_q     = a_r;
  assign div_bus.div_m     = b_r;

  calc_shift_mul u_mul (
    .clk   (clk),
    .rst_n (clr),
    .load  (mul_load),
    .step  (mul_step),
    .a     (a_r),
    .b     (b_r),
    .prod  (mul_prod),
    .done  (mul_done)
  );

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state, control strobes and the value to be latched on entry to DONE.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ld_res      = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    div_start_c = 1'b0;
    res_nxt     = result;
    neg_nxt     = 1'b0;
    err_nxt     = 1'b0;
    valid       = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (go) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_ADD: begin
            ld_res    = 1'b1;
            res_nxt   = {{(RESW-OPW-1){1'b0}}, sum5};
            state_nxt = S_DONE;
          end
          OP_SUB: begin
            ld_res    = 1'b1;
            res_nxt   = {{(RESW-OPW-1){diff5[OPW]}}, diff5};
            neg_nxt   = diff5[OPW];  // borrow out means A < B
            state_nxt = S_DONE;
          end
          OP_MUL: begin
            mul_load  = 1'b1;
            state_nxt = S_MUL;
          end
          OP_DIV: begin
            if (b_r == '0) begin
              ld_res    = 1'b1;
              res_nxt   = '0;
              err_nxt   = 1'b1;
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_DIV_REQ;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          ld_res    = 1'b1;
          res_nxt   = mul_prod;
          state_nxt = S_DONE;
        end
      end
      S_DIV_REQ: begin
        div_start_c = 1'b1;
        state_nxt   = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        // A completion on the timeout cycle still counts as success.
        if (div_bus.div_done) begin
          ld_res    = 1'b1;
          res_nxt   = {div_bus.div_rem, div_bus.div_quot};
          state_nxt = S_DONE;
        end else if (wait_last) begin
          ld_res    = 1'b1;
          res_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        valid     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at acceptance; result/flags update only on entry to DONE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= op_t'(op);
        err  <= 1'b0;
      end
      if (ld_res) begin
        result <= res_nxt;
        neg    <= neg_nxt;
        err    <= err_nxt;
      end
    end
  end

  // Divider wait counter: zero outside DIV_WAIT, counts cycles spent inside.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                     wait_cnt <= '0;
    else if (state == S_DIV_WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                          wait_cnt <= '0;
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a behavioural divider model.
// Latency: measured from the accepting edge to the edge that sees valid.
// Backpressure: go pulses while busy must be dropped.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       go;
  logic [1:0] op;
  logic [3:0] a, b;
  logic [7:0] result;
  logic       neg, err, valid, busy;

  calc_op_sequencer_if dif();

  calc_op_sequencer #(.DIV_TIMEOUT(32)) dut (
    .clk     (clk),
    .clr     (clr),
    .go      (go),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .neg     (neg),
    .err     (err),
    .valid   (valid),
    .busy    (busy),
    .div_bus (dif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Divider model: answers div_delay cycles after seeing div_start, or never.
  int div_delay = 5;
  bit div_never = 1'b0;
  int dly_cnt   = 0;
  int mq, mr;

  always @(negedge clk) begin
    dif.div_done = 1'b0;
    if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) begin
        dif.div_done = 1'b1;
        dif.div_quot = 4'(mq);
        dif.div_rem  = 4'(mr);
      end
    end
    if (dif.div_start && !div_never) begin
      mq      = int'(dif.div_q) / int'(dif.div_m);
      mr      = int'(dif.div_q) % int'(dif.div_m);
      dly_cnt = div_delay;
    end
  end

  int         lat, bcnt, ds_cnt, vcnt;
  logic [3:0] cap_q, cap_m;
  logic       err0, busy_after;
  logic [7:0] res0;

  // One operation: go for one accepting edge, inputs scrambled afterwards.
  task automatic do_op(input logic [1:0] o, input logic [3:0] aa, input logic [3:0] bb,
                       input bit noisy);
    int n;
    @(negedge clk);
    op = o; a = aa; b = bb; go = 1'b1;
    @(posedge clk);
    n = 0; lat = 0; bcnt = 0; ds_cnt = 0; cap_q = '0; cap_m = '0;
    while (lat == 0 && n < 100) begin
      @(negedge clk);
      go = noisy && n >= 1 && n <= 3;
      if (n == 0) begin
        a = ~aa; b = ~bb; op = ~o;
        err0 = err; res0 = result;
      end
      if (busy) bcnt++;
      if (dif.div_start) begin
        ds_cnt++; cap_q = dif.div_q; cap_m = dif.div_m;
      end
      if (valid) lat = n + 1;
      n++;
    end
    if (lat == 0) lat = 999;
    @(negedge clk);
    go = 1'b0;
    busy_after = busy;
  endtask

  initial begin
    clr = 1'b0; go = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("rst_result", result, 8'h00);
    check("rst_flags", {neg, err, valid, busy, dif.div_start}, 5'b0);
    @(negedge clk); clr = 1'b1;

    do_op(2'b00, 4'd9, 4'd7, 1'b0);
    check("add_lat", lat, 2);
    check("add_res", result, 8'h10);
    check("add_negerr", {neg, err}, 2'b00);
    check("add_busy", bcnt, 2);
    check("add_busy_fall", busy_after, 1'b0);

    do_op(2'b01, 4'd3, 4'd5, 1'b0);
    check("sub_lat", lat, 2);
    check("sub_res", result, 8'hFE);
    check("sub_neg", neg, 1'b1);

    do_op(2'b01, 4'd5, 4'd3, 1'b0);
    check("sub_hold", res0, 8'hFE);
    check("sub2_res", result, 8'h02);
    check("sub2_neg", neg, 1'b0);

    do_op(2'b11, 4'd15, 4'd15, 1'b0);
    check("mul_lat", lat, 6);
    check("mul_res", result, 8'hE1);

    do_op(2'b11, 4'd0, 4'd9, 1'b0);
    check("mul0_res", result, 8'h00);

    div_never = 1'b0; div_delay = 5;
    do_op(2'b10, 4'd13, 4'd4, 1'b0);
    check("div_start_cnt", ds_cnt, 1);
    check("div_q", cap_q, 4'd13);
    check("div_m", cap_m, 4'd4);
    check("div_lat", lat, 8);
    check("div_res", result, 8'h13);
    check("div_err", err, 1'b0);

    do_op(2'b10, 4'd7, 4'd0, 1'b0);
    check("dz_start_cnt", ds_cnt, 0);
    check("dz_lat", lat, 2);
    check("dz_err", err, 1'b1);
    check("dz_res", result, 8'h00);

    do_op(2'b10, 4'd13, 4'd4, 1'b0);
    check("err_clr_at_go", err0, 1'b0);
    check("div2_res", result, 8'h13);

    div_never = 1'b1;
    do_op(2'b10, 4'd7, 4'd2, 1'b0);
    check("tmo_lat", lat, 35);
    check("tmo_err", err, 1'b1);
    check("tmo_res", result, 8'h00);
    div_never = 1'b0;

    div_delay = 32;
    do_op(2'b10, 4'd9, 4'd2, 1'b0);
    check("tie_lat", lat, 35);
    check("tie_err", err, 1'b0);
    check("tie_res", result, 8'h14);
    div_delay = 5;

    do_op(2'b11, 4'd3, 4'd5, 1'b1);
    check("noisy_lat", lat, 6);
    check("noisy_res", result, 8'h0F);
    check("noisy_idle", busy_after, 1'b0);

    // Reset while the multiplier is stepping.
    do_op(2'b10, 4'd9, 4'd2, 1'b0);
    @(negedge clk); op = 2'b11; a = 4'd15; b = 4'd15; go = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("mulrst_result", result, 8'h00);
    check("mulrst_flags", {neg, err, valid, busy, dif.div_start}, 5'b0);
    @(negedge clk); clr = 1'b1;

    do_op(2'b00, 4'd1, 4'd1, 1'b0);
    check("post_rst_add", result, 8'h02);
    check("post_rst_lat", lat, 2);

    // Reset during DIV_WAIT; the late div_done must not produce a result.
    @(negedge clk); op = 2'b10; a = 4'd13; b = 4'd4; go = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk); clr = 1'b1;
    vcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("divrst_no_valid", vcnt, 0);
    check("divrst_idle", busy, 1'b0);
    check("divrst_result", result, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
